// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and sign helper for the HI/LO write sequencer.
package hilo_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_e;

   localparam int DIV_ITER_DEFAULT = 32;

   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
      return neg ? (-x) : x;
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-side request and HI/LO register-file write bundle.
interface hilo_muldiv_ctrl_if;
   import hilo_pkg::*;

   logic        op_valid;
   op_e         op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall_req;
   logic        busy;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   modport master (
      output op_valid, op, src_a, src_b, flush,
      input  stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata
   );

   modport slave (
      input  op_valid, op, src_a, src_b, flush,
      output stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata
   );

endinterface

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module hilo_div_iter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [32:0] rem_shift;
   logic [31:0] rem_sub;
   logic        fits;

   // The quotient register starts as the dividend and shifts its bits into the remainder.
   assign rem_shift = {rem_q, quo_q[31]};
   assign fits      = rem_shift >= {1'b0, dvs_q};
   assign rem_sub   = rem_shift[31:0] - dvs_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         rem_q <= fits ? rem_sub : rem_shift[31:0];
         quo_q <= {quo_q[30:0], fits};
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MT* pass-through, held multiply result, iterative divide.
module hilo_muldiv_ctrl
   import hilo_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_ITER   = DIV_ITER_DEFAULT
) (
   input  logic                clk,
   input  logic                resetn,
   hilo_muldiv_ctrl_if.slave   bus
);

   localparam int CNT_W = 6;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      prod_q, prod_d;
   logic [31:0]      a_raw_q, a_raw_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             div0_q, div0_d;
   logic             is_div_q, is_div_d;
   logic             hi_we_q, hi_we_d;
   logic             lo_we_q, lo_we_d;
   logic [31:0]      hi_wdata_q, hi_wdata_d;
   logic [31:0]      lo_wdata_q, lo_wdata_d;

   logic             stall;
   logic             div_start;
   logic             div_step;
   logic             op_signed;
   logic [31:0]      a_abs, b_abs;
   logic [31:0]      quotient, remainder;
   logic [63:0]      prod_s, prod_u;

   assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign a_abs     = neg_if(op_signed && bus.src_a[31], bus.src_a);
   assign b_abs     = neg_if(op_signed && bus.src_b[31], bus.src_b);
   assign prod_s    = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
                      $signed({{32{bus.src_b[31]}}, bus.src_b});
   assign prod_u    = {32'd0, bus.src_a} * {32'd0, bus.src_b};

   hilo_div_iter u_div (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (div_start),
      .step_i      (div_step),
      .dividend_i  (a_abs),
      .divisor_i   (b_abs),
      .quotient_o  (quotient),
      .remainder_o (remainder)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      a_raw_d    = a_raw_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      div0_d     = div0_q;
      is_div_d   = is_div_q;
      hi_we_d    = 1'b0;
      lo_we_d    = 1'b0;
      hi_wdata_d = hi_wdata_q;
      lo_wdata_d = lo_wdata_q;
      stall      = 1'b0;
      div_start  = 1'b0;
      div_step   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.op_valid && !bus.flush) begin
               case (bus.op)
                  OP_MTHI: begin
                     hi_we_d    = 1'b1;
                     hi_wdata_d = bus.src_a;
                  end
                  OP_MTLO: begin
                     lo_we_d    = 1'b1;
                     lo_wdata_d = bus.src_a;
                  end
                  OP_MULT, OP_MULTU: begin
                     stall    = 1'b1;
                     prod_d   = op_signed ? prod_s : prod_u;
                     is_div_d = 1'b0;
                     cnt_d    = CNT_W'(MUL_CYCLES);
                     state_d  = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     stall     = 1'b1;
                     div_start = 1'b1;
                     sign_a_d  = op_signed && bus.src_a[31];
                     sign_b_d  = op_signed && bus.src_b[31];
                     a_raw_d   = bus.src_a;
                     div0_d    = (bus.src_b == 32'd0);
                     is_div_d  = 1'b1;
                     cnt_d     = CNT_W'(DIV_ITER);
                     state_d   = DIV;
                  end
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               stall    = 1'b1;
               div_step = (state_q == DIV);
               if (cnt_q == CNT_W'(1)) state_d = DONE;
               else                    cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            // Sign fixup and divide-by-zero forcing resolve here; the write lands on the next edge.
            if (!bus.flush) begin
               hi_we_d = 1'b1;
               lo_we_d = 1'b1;
               if (!is_div_q) begin
                  hi_wdata_d = prod_q[63:32];
                  lo_wdata_d = prod_q[31:0];
               end else if (div0_q) begin
                  hi_wdata_d = a_raw_q;
                  lo_wdata_d = 32'hFFFF_FFFF;
               end else begin
                  hi_wdata_d = neg_if(sign_a_q, remainder);
                  lo_wdata_d = neg_if(sign_a_q ^ sign_b_q, quotient);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         prod_q     <= '0;
         a_raw_q    <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div0_q     <= 1'b0;
         is_div_q   <= 1'b0;
         hi_we_q    <= 1'b0;
         lo_we_q    <= 1'b0;
         hi_wdata_q <= '0;
         lo_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         a_raw_q    <= a_raw_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         div0_q     <= div0_d;
         is_div_q   <= is_div_d;
         hi_we_q    <= hi_we_d;
         lo_we_q    <= lo_we_d;
         hi_wdata_q <= hi_wdata_d;
         lo_wdata_q <= lo_wdata_d;
      end
   end

   assign bus.stall_req = stall;
   assign bus.busy      = (state_q != IDLE);
   assign bus.hi_we     = hi_we_q;
   assign bus.lo_we     = lo_we_q;
   assign bus.hi_wdata  = hi_wdata_q;
   assign bus.lo_wdata  = lo_wdata_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: stimulus queues expected writes, a monitor pops them.
module tb_hilo_muldiv_ctrl;
   import hilo_pkg::*;

   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   hilo_muldiv_ctrl_if bus ();

   hilo_muldiv_ctrl #(.MUL_CYCLES(2), .DIV_ITER(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (resetn && (bus.hi_we || bus.lo_we)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.hi_we, bus.lo_we}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            a = '{bus.hi_we, bus.lo_we,
                  e.hi_we ? bus.hi_wdata : 32'd0,
                  e.lo_we ? bus.lo_wdata : 32'd0};
            check("write", a, e);
         end
      end
   end

   task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input exp_t e);
      int n;
      n = 0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = op;
      bus.src_a    = a;
      bus.src_b    = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.stall_req) n++;
         else break;
      end
      check($sformatf("stall_%s", op.name()), n, exp_stall);
      if (exp_stall > 0) begin
         @(posedge clk); #1;
         bus.op_valid = 1'b0;
         @(negedge clk);
         check("write_latency", {bus.hi_we, bus.lo_we}, 2'b11);
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      resetn       = 1'b0;
      bus.op_valid = 1'b0;
      bus.op       = OP_MULT;
      bus.src_a    = '0;
      bus.src_b    = '0;
      bus.flush    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {bus.stall_req, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata}, '0);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_we", {bus.hi_we, bus.lo_we, bus.busy}, 3'b000);

      issue(OP_MULT,  32'hFFFF_FFFD, 32'd5,        3,  '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001});
      issue(OP_DIVU,  32'd100,       32'd7,        33, '{1'b1, 1'b1, 32'd2,         32'd14});
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, '{1'b1, 1'b1, 32'd1,         32'hFFFF_FFFD});
      issue(OP_DIV,   32'h1234_5678, 32'd0,        33, '{1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF});

      issue(OP_MTHI, 32'hAAAA_0000, 32'd0, 0, '{1'b1, 1'b0, 32'hAAAA_0000, 32'd0});
      issue(OP_MTLO, 32'h0000_BBBB, 32'd0, 0, '{1'b0, 1'b1, 32'd0,         32'h0000_BBBB});
      go_idle();
      repeat (2) @(negedge clk);

      // Flush in the 10th DIV cycle.
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = OP_DIVU;
      bus.src_a    = 32'd500;
      bus.src_b    = 32'd9;
      repeat (10) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      check("flush_stall_busy", {bus.stall_req, bus.busy}, 2'b01);
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      @(negedge clk);
      check("flush_idle", bus.busy, 1'b0);
      issue(OP_MULTU, 32'd3, 32'd4, 3, '{1'b1, 1'b1, 32'd0, 32'd12});

      // Reset in the 20th DIV cycle.
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = OP_DIVU;
      bus.src_a    = 32'd1000;
      bus.src_b    = 32'd3;
      repeat (20) @(posedge clk);
      #1;
      resetn       = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      check("midop_reset_outputs",
            {bus.stall_req, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata}, '0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("release_no_write", {bus.hi_we, bus.lo_we, bus.busy}, 3'b000);
      repeat (40) @(negedge clk);
      check("release_stays_idle", {bus.hi_we, bus.lo_we, bus.busy}, 3'b000);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
